// File: rtl/ahb_uart_v2_if.sv
// AHB-Lite slave-side bus bundle for ahb_uart_v2.
interface ahb_uart_v2_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              hsel_i;
  logic              hwrite_i;
  logic              hready_i;
  logic [1:0]        htrans_i;
  logic [2:0]        hsize_i;
  logic [AWIDTH-1:0] haddr_i;
  logic [DWIDTH-1:0] hwdata_i;
  logic              hreadyout_o;
  logic              hresp_o;
  logic [DWIDTH-1:0] hrdata_o;

  modport slave (
    input  hsel_i, hwrite_i, hready_i, htrans_i, hsize_i, haddr_i, hwdata_i,
    output hreadyout_o, hresp_o, hrdata_o
  );

  modport master (
    output hsel_i, hwrite_i, hready_i, htrans_i, hsize_i, haddr_i, hwdata_i,
    input  hreadyout_o, hresp_o, hrdata_o
  );
endinterface

// File: rtl/ahb_uart_v2.sv
// AHB-Lite UART: programmable divisor, optional parity, 1/2 stop bits,
// TX/RX FIFOs, sticky error flags, level reporting and a level interrupt.
module ahb_uart_v2 #(
  parameter int          AWIDTH    = 32,
  parameter int          DWIDTH    = 32,
  parameter int          DEPTH     = 16,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic           hclk,
  input  logic           hresetn,
  ahb_uart_v2_if.slave   bus,
  output logic           irq_o,
  output logic           tx,
  input  logic           rx
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  // ---------------- bus address/data phase ----------------
  logic       r_wr, r_rd;
  logic [2:0] r_addr;
  logic       w_sel;
  assign w_sel = bus.hsel_i & bus.hready_i & bus.htrans_i[1];

  // Capture the address phase; the access completes in the next cycle.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_addr <= 3'd0;
    end else begin
      r_wr   <= w_sel & bus.hwrite_i;
      r_rd   <= w_sel & ~bus.hwrite_i;
      r_addr <= bus.haddr_i[4:2];
    end
  end

  logic w_wr_data, w_wr_ctrl, w_wr_baud, w_wr_stat, w_rd_data;
  assign w_wr_data = r_wr & (r_addr == 3'd0);
  assign w_wr_ctrl = r_wr & (r_addr == 3'd1);
  assign w_wr_baud = r_wr & (r_addr == 3'd2);
  assign w_wr_stat = r_wr & (r_addr == 3'd3);
  assign w_rd_data = r_rd & (r_addr == 3'd0);

  // hsize, htrans[0] and upper address/data bits carry nothing for this slave
  logic w_unused;
  assign w_unused = &{1'b0, bus.hsize_i, bus.htrans_i[0], bus.haddr_i, bus.hwdata_i};

  // ---------------- configuration registers ----------------
  logic [6:0]  r_ctrl;
  logic [15:0] r_div;
  logic [15:0] w_div_eff;
  assign w_div_eff = (r_div < 16'd3) ? 16'd3 : r_div;

  // CTRL and BAUD writes.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_ctrl <= 7'd0;
      r_div  <= DIV_RESET;
    end else begin
      if (w_wr_ctrl) r_ctrl <= bus.hwdata_i[6:0];
      if (w_wr_baud) r_div  <= bus.hwdata_i[15:0];
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    r_txf_mem [DEPTH];
  logic [PW-1:0] r_txf_wp, r_txf_rp;
  logic [CW-1:0] r_txf_cnt;
  logic          w_txf_full, w_txf_empty, w_txf_push, w_txf_pop;
  assign w_txf_full  = (r_txf_cnt == CW'(DEPTH));
  assign w_txf_empty = (r_txf_cnt == '0);
  assign w_txf_push  = w_wr_data & ~w_txf_full;

  // TX FIFO storage.
  always_ff @(posedge hclk) begin
    if (w_txf_push) r_txf_mem[r_txf_wp] <= bus.hwdata_i[7:0];
  end

  // TX FIFO pointers and occupancy (push and pop may coincide).
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_txf_wp  <= '0;
      r_txf_rp  <= '0;
      r_txf_cnt <= '0;
    end else begin
      if (w_txf_push) r_txf_wp <= r_txf_wp + PW'(1);
      if (w_txf_pop)  r_txf_rp <= r_txf_rp + PW'(1);
      case ({w_txf_push, w_txf_pop})
        2'b10:   r_txf_cnt <= r_txf_cnt + CW'(1);
        2'b01:   r_txf_cnt <= r_txf_cnt - CW'(1);
        default: r_txf_cnt <= r_txf_cnt;
      endcase
    end
  end

  // ---------------- TX engine ----------------
  tx_state_t   r_tx_st;
  logic [15:0] r_tx_cnt, r_tx_div;
  logic [7:0]  r_tx_sh;
  logic [2:0]  r_tx_bit;
  logic        r_tx_par_en, r_tx_par, r_tx_stop2, r_tx;
  logic        w_tx_last, w_tx_busy;
  logic [7:0]  w_tx_byte;

  assign w_tx_busy = (r_tx_st != TX_IDLE);
  assign w_tx_last = (r_tx_st == TX_STOP) & (r_tx_cnt == 16'd0) & ~r_tx_stop2;
  assign w_tx_byte = r_txf_mem[r_txf_rp];
  // Pop while idle, or in the final cycle of a frame for gapless streaming.
  assign w_txf_pop = r_ctrl[0] & ~w_txf_empty & (~w_tx_busy | w_tx_last);
  assign tx        = r_tx;

  // TX frame sequencer; frame settings are frozen at pop time.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_tx_st     <= TX_IDLE;
      r_tx_cnt    <= 16'd0;
      r_tx_div    <= 16'd3;
      r_tx_sh     <= 8'd0;
      r_tx_bit    <= 3'd0;
      r_tx_par_en <= 1'b0;
      r_tx_par    <= 1'b0;
      r_tx_stop2  <= 1'b0;
      r_tx        <= 1'b1;
    end else if (w_txf_pop) begin
      r_tx_st     <= TX_START;
      r_tx        <= 1'b0;
      r_tx_cnt    <= w_div_eff;
      r_tx_div    <= w_div_eff;
      r_tx_sh     <= w_tx_byte;
      r_tx_bit    <= 3'd0;
      r_tx_par_en <= r_ctrl[2];
      r_tx_par    <= (^w_tx_byte) ^ r_ctrl[3];
      r_tx_stop2  <= r_ctrl[4];
    end else if (r_tx_st == TX_IDLE) begin
      r_tx <= 1'b1;
    end else if (r_tx_cnt != 16'd0) begin
      r_tx_cnt <= r_tx_cnt - 16'd1;
    end else begin
      r_tx_cnt <= r_tx_div;
      case (r_tx_st)
        TX_START: begin
          r_tx_st <= TX_DATA;
          r_tx    <= r_tx_sh[0];
        end
        TX_DATA: begin
          if (r_tx_bit == 3'd7) begin
            r_tx_st <= r_tx_par_en ? TX_PAR : TX_STOP;
            r_tx    <= r_tx_par_en ? r_tx_par : 1'b1;
          end else begin
            r_tx_bit <= r_tx_bit + 3'd1;
            r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
            r_tx     <= r_tx_sh[1];
          end
        end
        TX_PAR: begin
          r_tx_st <= TX_STOP;
          r_tx    <= 1'b1;
        end
        default: begin
          if (r_tx_stop2) r_tx_stop2 <= 1'b0;
          else            r_tx_st    <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX engine ----------------
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_t   r_rx_st;
  logic [15:0] r_rx_cnt, r_rx_div;
  logic [7:0]  r_rx_sh;
  logic [2:0]  r_rx_bit;
  logic        r_rx_par_en, r_rx_par_odd;
  logic        w_rx_fall, w_rx_busy, w_rx_stop_smp, w_rx_par_smp;
  logic [16:0] w_half_sum;
  logic [15:0] w_rx_half;

  assign w_rx_fall     = r_rx_prev & ~r_rx_s2;
  assign w_rx_busy     = (r_rx_st != RX_IDLE);
  assign w_rx_stop_smp = (r_rx_st == RX_STOP) & (r_rx_cnt == 16'd0);
  assign w_rx_par_smp  = (r_rx_st == RX_PAR) & (r_rx_cnt == 16'd0);
  assign w_half_sum    = {1'b0, w_div_eff} + 17'd1;
  assign w_rx_half     = w_half_sum[16:1] - 16'd1;

  // Two-flop synchroniser plus previous value for edge detection.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // RX frame sequencer: half-bit start check, then centre sampling.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_rx_st      <= RX_IDLE;
      r_rx_cnt     <= 16'd0;
      r_rx_div     <= 16'd3;
      r_rx_sh      <= 8'd0;
      r_rx_bit     <= 3'd0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
    end else if (r_rx_st == RX_IDLE) begin
      if (r_ctrl[1] && w_rx_fall) begin
        r_rx_st      <= RX_START;
        r_rx_cnt     <= w_rx_half;
        r_rx_div     <= w_div_eff;
        r_rx_bit     <= 3'd0;
        r_rx_par_en  <= r_ctrl[2];
        r_rx_par_odd <= r_ctrl[3];
      end
    end else if (r_rx_cnt != 16'd0) begin
      r_rx_cnt <= r_rx_cnt - 16'd1;
    end else begin
      r_rx_cnt <= r_rx_div;
      case (r_rx_st)
        RX_START: r_rx_st <= r_rx_s2 ? RX_IDLE : RX_DATA;
        RX_DATA: begin
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) r_rx_st <= r_rx_par_en ? RX_PAR : RX_STOP;
        end
        RX_PAR:  r_rx_st <= RX_STOP;
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    r_rxf_mem [DEPTH];
  logic [PW-1:0] r_rxf_wp, r_rxf_rp;
  logic [CW-1:0] r_rxf_cnt;
  logic          w_rxf_full, w_rxf_empty, w_rxf_push, w_rxf_pop;
  assign w_rxf_full  = (r_rxf_cnt == CW'(DEPTH));
  assign w_rxf_empty = (r_rxf_cnt == '0);
  assign w_rxf_push  = w_rx_stop_smp & r_rx_s2 & ~w_rxf_full;
  assign w_rxf_pop   = w_rd_data & ~w_rxf_empty;

  // RX FIFO storage.
  always_ff @(posedge hclk) begin
    if (w_rxf_push) r_rxf_mem[r_rxf_wp] <= r_rx_sh;
  end

  // RX FIFO pointers and occupancy (push and pop may coincide).
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_rxf_wp  <= '0;
      r_rxf_rp  <= '0;
      r_rxf_cnt <= '0;
    end else begin
      if (w_rxf_push) r_rxf_wp <= r_rxf_wp + PW'(1);
      if (w_rxf_pop)  r_rxf_rp <= r_rxf_rp + PW'(1);
      case ({w_rxf_push, w_rxf_pop})
        2'b10:   r_rxf_cnt <= r_rxf_cnt + CW'(1);
        2'b01:   r_rxf_cnt <= r_rxf_cnt - CW'(1);
        default: r_rxf_cnt <= r_rxf_cnt;
      endcase
    end
  end

  // ---------------- sticky flags {tx_ovf, frm_err, par_err, rx_ovr} ----------------
  logic [3:0] r_sticky, w_set, w_clr;
  assign w_set = {w_wr_data & w_txf_full,
                  w_rx_stop_smp & ~r_rx_s2,
                  w_rx_par_smp & (r_rx_s2 != ((^r_rx_sh) ^ r_rx_par_odd)),
                  w_rx_stop_smp & r_rx_s2 & w_rxf_full};
  assign w_clr = w_wr_stat ? bus.hwdata_i[11:8] : 4'd0;

  // Set wins over a simultaneous write-1-to-clear.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_sticky <= 4'd0;
    else          r_sticky <= (r_sticky & ~w_clr) | w_set;
  end

  // ---------------- read mux and outputs ----------------
  logic [DWIDTH-1:0] w_rdata;

  // Data-phase read data, zero when no read is in progress.
  always_comb begin
    w_rdata = '0;
    if (r_rd) begin
      case (r_addr)
        3'd0: w_rdata[7:0]  = w_rxf_empty ? 8'd0 : r_rxf_mem[r_rxf_rp];
        3'd1: w_rdata[6:0]  = r_ctrl;
        3'd2: w_rdata[15:0] = r_div;
        3'd3: begin
          w_rdata[5:0]  = {w_rx_busy, w_tx_busy, w_rxf_empty, w_rxf_full, w_txf_empty, w_txf_full};
          w_rdata[11:8] = r_sticky;
        end
        3'd4: begin
          w_rdata[7:0]  = 8'(r_txf_cnt);
          w_rdata[15:8] = 8'(r_rxf_cnt);
        end
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.hrdata_o    = w_rdata;
  assign bus.hreadyout_o = 1'b1;
  assign bus.hresp_o     = 1'b0;
  assign irq_o = (r_ctrl[5] & ~w_rxf_empty) |
                 (r_ctrl[6] & w_txf_empty & ~w_tx_busy) |
                 (r_ctrl[5] & (|r_sticky[2:0]));
endmodule

// File: tb/tb_ahb_uart_v2.sv
// Self-checking bench for ahb_uart_v2: directed scenarios plus randomized loopback.
module tb_ahb_uart_v2;
  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  ahb_uart_v2_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();
  logic irq, tx, rx;
  logic rx_drv  = 1'b1;
  logic loop_en = 1'b0;
  assign rx = loop_en ? tx : rx_drv;

  ahb_uart_v2 #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .DIV_RESET(16'd433)) dut (
    .hclk(hclk), .hresetn(hresetn), .bus(bus), .irq_o(irq), .tx(tx), .rx(rx));

  int checks = 0;
  int errors = 0;

  // Reference parity bit: total number of ones (data + parity) even, or odd when odd=1.
  function automatic logic exp_par(input logic [7:0] d, input logic odd);
    return logic'(($countones(d) % 2) == 1) ^ odd;
  endfunction

  task automatic do_reset();
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    @(posedge hclk); #1;
    hresetn = 1'b0;
    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge hclk); #1;
    bus.hsel_i = 1'b1; bus.htrans_i = 2'b10; bus.hwrite_i = 1'b1; bus.haddr_i = {27'd0, a};
    @(posedge hclk); #1;
    bus.hsel_i = 1'b0; bus.htrans_i = 2'b00; bus.hwrite_i = 1'b0; bus.hwdata_i = d;
    $display("WR addr=%02h data=%08h", a, d);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(posedge hclk); #1;
    bus.hsel_i = 1'b1; bus.htrans_i = 2'b10; bus.hwrite_i = 1'b0; bus.haddr_i = {27'd0, a};
    @(posedge hclk); #1;
    bus.hsel_i = 1'b0; bus.htrans_i = 2'b00;
    d = bus.hrdata_o;
    $display("RD addr=%02h data=%08h", a, d);
  endtask

  // Drive one serial frame on rx with div+1 cycles per bit.
  task automatic send_frame(input logic [7:0] d, input int div, input logic par_en,
                            input logic par_bit, input logic stop_bit);
    logic [10:0] bits;
    int n;
    bits = 11'd0;
    bits[8:1] = d;
    if (par_en) begin bits[9] = par_bit; bits[10] = stop_bit; n = 11; end
    else begin bits[9] = stop_bit; n = 10; end
    @(posedge hclk); #1;
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      repeat (div + 1) @(posedge hclk);
      #1;
    end
    rx_drv = 1'b1;
    $display("RXFRAME data=%02h par_en=%0d par=%0d stop=%0d", d, par_en, par_bit, stop_bit);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (bus.hrdata_o !== 32'd0) begin errors++; $display("FAIL reset_hrdata got=%h exp=0", bus.hrdata_o); end
    checks++; if (bus.hreadyout_o !== 1'b1 || bus.hresp_o !== 1'b0) begin
      errors++; $display("FAIL reset_resp got=%b%b exp=10", bus.hreadyout_o, bus.hresp_o); end
    bus_read(5'h04, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    bus_read(5'h08, d);
    checks++; if (d !== 32'd433) begin errors++; $display("FAIL reset_baud got=%h exp=%h", d, 32'd433); end
    bus_read(5'h0C, d);
    checks++; if (d !== 32'h0A) begin errors++; $display("FAIL reset_status got=%h exp=0000000a", d); end
    bus_read(5'h10, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_level got=%h exp=0", d); end
  endtask

  task automatic test_loopback();
    logic [31:0] d;
    logic [9:0]  fr;
    int k;
    bit bad;
    do_reset();
    loop_en = 1'b1;
    bus_write(5'h08, 32'd3);
    bus_write(5'h04, 32'h3);
    bus_write(5'h00, 32'hA5);
    fr = {1'b1, 8'hA5, 1'b0};
    k = 0;
    while (tx !== 1'b0 && k < 10) begin @(posedge hclk); #1; k++; end
    checks++; if (k > 2) begin errors++; $display("FAIL tx_start_latency got=%0d exp<=2", k); end
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (tx !== fr[b]) bad = 1'b1;
        @(posedge hclk); #1;
      end
      checks++; if (bad) begin errors++; $display("FAIL loopback_bit%0d got=%b exp=%b", b, ~fr[b], fr[b]); end
    end
    bus_read(5'h0C, d);
    checks++; if (d[4] !== 1'b0) begin errors++; $display("FAIL loopback_tx_busy got=%b exp=0", d[4]); end
    k = 0; d = 32'd0;
    while (d[15:8] !== 8'd1 && k < 40) begin bus_read(5'h10, d); k++; end
    checks++; if (d[15:8] !== 8'd1) begin errors++; $display("FAIL loopback_rx_level got=%0d exp=1", d[15:8]); end
    bus_read(5'h00, d);
    checks++; if (d !== 32'hA5) begin errors++; $display("FAIL loopback_data got=%h exp=a5", d); end
    bus_read(5'h0C, d);
    checks++; if (d[3] !== 1'b1) begin errors++; $display("FAIL loopback_rx_empty got=%b exp=1", d[3]); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    logic [7:0]  q[$];
    logic [7:0]  b, got;
    int k;
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'($urandom);
      if (i < DEPTH) q.push_back(b);
      bus_write(5'h00, {24'd0, b});
    end
    bus_read(5'h10, d);
    checks++; if (d[7:0] !== 8'(DEPTH)) begin errors++; $display("FAIL txovf_level got=%0d exp=%0d", d[7:0], DEPTH); end
    bus_read(5'h0C, d);
    checks++; if (d[11] !== 1'b1 || d[0] !== 1'b1) begin
      errors++; $display("FAIL txovf_flags got ovf=%b full=%b exp=1,1", d[11], d[0]); end
    bus_write(5'h0C, 32'h800);
    bus_read(5'h0C, d);
    checks++; if (d[11] !== 1'b0) begin errors++; $display("FAIL txovf_clear got=%b exp=0", d[11]); end
    bus_write(5'h08, 32'd3);
    bus_write(5'h04, 32'h1);
    k = 0;
    while (tx !== 1'b0 && k < 20) begin @(posedge hclk); #1; k++; end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL txovf_start got=%b exp=0", tx); end
    got = 8'd0;
    repeat (6) @(posedge hclk);
    #1;
    for (int i = 0; i < 8; i++) begin
      got[i] = tx;
      repeat (4) @(posedge hclk);
      #1;
    end
    checks++; if (got !== q[0]) begin errors++; $display("FAIL txovf_first_byte got=%h exp=%h", got, q[0]); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    logic [7:0]  q[$];
    logic [7:0]  b;
    do_reset();
    bus_write(5'h08, 32'd3);
    bus_write(5'h04, 32'h2);
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'($urandom);
      if (i < DEPTH) q.push_back(b);
      send_frame(b, 3, 1'b0, 1'b0, 1'b1);
    end
    repeat (8) @(posedge hclk);
    bus_read(5'h0C, d);
    checks++; if (d[2] !== 1'b1 || d[8] !== 1'b1) begin
      errors++; $display("FAIL rxovr_flags got full=%b ovr=%b exp=1,1", d[2], d[8]); end
    bus_read(5'h10, d);
    checks++; if (d[15:8] !== 8'(DEPTH)) begin errors++; $display("FAIL rxovr_level got=%0d exp=%0d", d[15:8], DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(5'h00, d);
      checks++; if (d !== {24'd0, q[i]}) begin errors++; $display("FAIL rxovr_data%0d got=%h exp=%h", i, d, q[i]); end
    end
    bus_read(5'h0C, d);
    checks++; if (d[3] !== 1'b1) begin errors++; $display("FAIL rxovr_empty got=%b exp=1", d[3]); end
  endtask

  task automatic test_parity();
    logic [31:0] d;
    do_reset();
    bus_write(5'h08, 32'd3);
    bus_write(5'h04, 32'h0E);
    send_frame(8'h03, 3, 1'b1, ~exp_par(8'h03, 1'b1), 1'b1);
    repeat (6) @(posedge hclk);
    bus_read(5'h0C, d);
    checks++; if (d[9] !== 1'b1) begin errors++; $display("FAIL parity_bad_err got=%b exp=1", d[9]); end
    bus_read(5'h00, d);
    checks++; if (d !== 32'h03) begin errors++; $display("FAIL parity_bad_data got=%h exp=03", d); end
    bus_write(5'h0C, 32'h200);
    send_frame(8'h03, 3, 1'b1, exp_par(8'h03, 1'b1), 1'b1);
    repeat (6) @(posedge hclk);
    bus_read(5'h0C, d);
    checks++; if (d[9] !== 1'b0) begin errors++; $display("FAIL parity_good_err got=%b exp=0", d[9]); end
    bus_read(5'h00, d);
    checks++; if (d !== 32'h03) begin errors++; $display("FAIL parity_good_data got=%h exp=03", d); end
  endtask

  task automatic test_frame_glitch();
    logic [31:0] d;
    do_reset();
    bus_write(5'h08, 32'd3);
    bus_write(5'h04, 32'h2);
    send_frame(8'h3C, 3, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge hclk);
    bus_read(5'h0C, d);
    checks++; if (d[10] !== 1'b1 || d[3] !== 1'b1) begin
      errors++; $display("FAIL frame_err got frm=%b empty=%b exp=1,1", d[10], d[3]); end
    bus_write(5'h0C, 32'h700);
    @(posedge hclk); #1 rx_drv = 1'b0;
    @(posedge hclk); #1 rx_drv = 1'b1;
    repeat (50) @(posedge hclk);
    bus_read(5'h0C, d);
    checks++; if (d[11:8] !== 4'd0 || d[3] !== 1'b1) begin
      errors++; $display("FAIL glitch got err=%h empty=%b exp=0,1", d[11:8], d[3]); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    do_reset();
    bus_write(5'h08, 32'd3);
    bus_write(5'h04, 32'h22);
    @(posedge hclk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=0", irq); end
    send_frame(8'h5A, 3, 1'b0, 1'b0, 1'b1);
    repeat (6) @(posedge hclk);
    #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx got=%b exp=1", irq); end
    bus_read(5'h00, d);
    checks++; if (d !== 32'h5A) begin errors++; $display("FAIL irq_data got=%h exp=5a", d); end
    @(posedge hclk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_read got=%b exp=0", irq); end
    bus_write(5'h04, 32'h40);
    @(posedge hclk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_empty got=%b exp=1", irq); end
  endtask

  task automatic test_min_div();
    int k, low;
    do_reset();
    bus_write(5'h08, 32'd1);
    bus_write(5'h04, 32'h1);
    bus_write(5'h00, 32'h00);
    k = 0;
    while (tx !== 1'b0 && k < 10) begin @(posedge hclk); #1; k++; end
    low = 0;
    while (tx === 1'b0 && low < 100) begin @(posedge hclk); #1; low++; end
    checks++; if (low !== 36) begin errors++; $display("FAIL min_div_low_cycles got=%0d exp=36", low); end
  endtask

  task automatic test_random_loopback();
    logic [31:0] d;
    logic [7:0]  q[$];
    logic [7:0]  b;
    int divs[5] = '{0, 2, 3, 5, 7};
    int n, k;
    logic [6:0] ctrl;
    do_reset();
    loop_en = 1'b1;
    for (int it = 0; it < 4; it++) begin
      ctrl = {2'b00, 1'($urandom), 1'($urandom), 1'($urandom), 2'b11};
      bus_write(5'h08, divs[$urandom_range(0, 4)]);
      bus_write(5'h04, {25'd0, ctrl});
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        q.push_back(b);
        bus_write(5'h00, {24'd0, b});
      end
      k = 0; d = 32'd0;
      while (d[15:8] !== 8'(n) && k < 600) begin bus_read(5'h10, d); k++; end
      checks++; if (d[15:8] !== 8'(n)) begin errors++; $display("FAIL rand%0d_level got=%0d exp=%0d", it, d[15:8], n); end
      for (int i = 0; i < n; i++) begin
        bus_read(5'h00, d);
        b = q.pop_front();
        checks++; if (d !== {24'd0, b}) begin errors++; $display("FAIL rand%0d_data%0d got=%h exp=%h", it, i, d, b); end
      end
      bus_read(5'h0C, d);
      checks++; if (d[11:8] !== 4'd0) begin errors++; $display("FAIL rand%0d_errs got=%h exp=0", it, d[11:8]); end
      repeat (40) @(posedge hclk);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    do_reset();
    bus_write(5'h08, 32'd3);
    bus_write(5'h04, 32'h23);
    bus_write(5'h00, 32'h00);
    repeat (12) @(posedge hclk);
    #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midframe_tx_low got=%b exp=0", tx); end
    hresetn = 1'b0;
    #2;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midframe_async_tx got=%b exp=1", tx); end
    @(posedge hclk); #1 hresetn = 1'b1;
    bus_read(5'h04, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL midframe_ctrl got=%h exp=0", d); end
    bus_read(5'h08, d);
    checks++; if (d !== 32'd433) begin errors++; $display("FAIL midframe_baud got=%h exp=1b1", d); end
    bus_read(5'h0C, d);
    checks++; if (d !== 32'h0A) begin errors++; $display("FAIL midframe_status got=%h exp=0a", d); end
    bus_read(5'h10, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL midframe_level got=%h exp=0", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hsel_i   = 1'b0;
    bus.hwrite_i = 1'b0;
    bus.hready_i = 1'b1;
    bus.htrans_i = 2'b00;
    bus.hsize_i  = 3'b010;
    bus.haddr_i  = '0;
    bus.hwdata_i = '0;
    test_reset();
    test_loopback();
    test_tx_overflow();
    test_rx_overrun();
    test_parity();
    test_frame_glitch();
    test_irq();
    test_min_div();
    test_random_loopback();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
